// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target exposing a register file through an 8-bit
// register pointer. A write transaction sets the pointer (register id byte)
// and then stores data bytes. A read transaction returns bytes starting at
// the current pointer.
//
// Ports
//   clk_i, rst_ni               system clock, async active-low reset
//   assigned_address_i [6:0]    primary 7-bit target address
//   aux_address_i [6:0]         secondary address, matched when aux_address_en_i=1
//   auto_inc_i                  pointer advances after each data byte when 1
//   scl_i, sda_i                raw bus levels (synchronised internally)
//   sda_oe_o                    1 = pull SDA low
//   write_register_id_o/value_o/enable_o   one-cycle register write strobe
//   read_register_id_o          current pointer; read_register_value_i answers it
//   busy_o                      high between accepted START and STOP/abort
//   dbg_state_o                 FSM state encoding
module i2c_reg_target #(
    parameter int REG_COUNT   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] assigned_address_i,
    input  logic [6:0] aux_address_i,
    input  logic       aux_address_en_i,
    input  logic       auto_inc_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] write_register_id_o,
    output logic [7:0] write_register_value_o,
    output logic       write_enable_o,
    output logic [7:0] read_register_id_o,
    input  logic [7:0] read_register_value_i,
    output logic       busy_o,
    output logic [3:0] dbg_state_o
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ACK_ADDR  = 4'd2,
        REG_ID    = 4'd3,
        ACK_REG   = 4'd4,
        WR_DATA   = 4'd5,
        ACK_WR    = 4'd6,
        RD_DATA   = 4'd7,
        GET_ACK   = 4'd8,
        NACK_WAIT = 4'd9
    } state_t;

    localparam logic [8:0] REG_LIMIT = 9'(REG_COUNT);
    localparam logic [7:0] REG_MAX   = 8'(REG_COUNT - 1);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic       we_q, we_d;
    logic [7:0] wid_q, wid_d;
    logic [7:0] wval_q, wval_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;

    logic [7:0] byte_in;
    logic [7:0] ptr_next;
    logic       addr_match;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // START/STOP need SCL high in both the previous and current sample so an
    // SDA change racing an SCL edge is not mistaken for a bus condition.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign byte_in    = {shift_q[6:0], sda_s};
    assign ptr_next   = (ptr_q == REG_MAX) ? 8'd0 : ptr_q + 8'd1;
    assign addr_match = (byte_in[7:1] == assigned_address_i) ||
                        (aux_address_en_i && (byte_in[7:1] == aux_address_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        we_d      = 1'b0;
        wid_d     = wid_q;
        wval_d    = wval_q;
        busy_d    = busy_q;
        rw_d      = rw_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG_ID, WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == ADDR) begin
                                rw_d    = byte_in[0];
                                state_d = addr_match ? ACK_ADDR : NACK_WAIT;
                            end else if (state_q == REG_ID) begin
                                if ({1'b0, byte_in} < REG_LIMIT) begin
                                    ptr_d   = byte_in;
                                    state_d = ACK_REG;
                                end else begin
                                    state_d = NACK_WAIT;
                                end
                            end else begin
                                we_d    = 1'b1;
                                wid_d   = ptr_q;
                                wval_d  = byte_in;
                                if (auto_inc_i) ptr_d = ptr_next;
                                state_d = ACK_WR;
                            end
                        end
                    end
                end
                // ACK phases: the first SCL fall starts the ACK, the second
                // (end of the 9th clock) ends it; sda_oe_q tells them apart.
                ACK_ADDR, ACK_REG, ACK_WR: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == ACK_ADDR && rw_q) begin
                                state_d  = RD_DATA;
                                shift_d  = read_register_value_i;
                                sda_oe_d = ~read_register_value_i[7];
                            end else if (state_q == ACK_ADDR) begin
                                state_d = REG_ID;
                            end else begin
                                state_d = WR_DATA;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (auto_inc_i) ptr_d = ptr_next;
                            state_d   = GET_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                // bit_cnt_q = 1 marks "controller ACKed" until the next fall.
                GET_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) bit_cnt_d = 4'd1;
                        else        state_d   = NACK_WAIT;
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = 4'd0;
                        state_d   = RD_DATA;
                        shift_d   = read_register_value_i;
                        sda_oe_d  = ~read_register_value_i[7];
                    end
                end
                IDLE, NACK_WAIT: ;
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            ptr_q     <= 8'd0;
            sda_oe_q  <= 1'b0;
            we_q      <= 1'b0;
            wid_q     <= 8'd0;
            wval_q    <= 8'd0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            we_q      <= we_d;
            wid_q     <= wid_d;
            wval_q    <= wval_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
        end
    end

    assign sda_oe_o               = sda_oe_q;
    assign write_enable_o         = we_q;
    assign write_register_id_o    = wid_q;
    assign write_register_value_o = wval_q;
    assign read_register_id_o     = ptr_q;
    assign busy_o                 = busy_q;
    assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged I2C controller on an
// open-drain bus shared by two targets (0x40 with REG_COUNT=256 and 0x50 with
// REG_COUNT=16). Write strobes of the first target go through a scoreboard.
module tb_i2c_reg_target;
    localparam int Q = 8;  // clk cycles per quarter SCL phase

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl, sda_drv;
    logic [6:0] aux_addr;
    logic       aux_en, auto_inc;
    logic       sda_bus;

    logic       oe_a, we_a, busy_a;
    logic [7:0] wid_a, wval_a, rid_a, rval_a;
    logic [3:0] st_a;
    logic       oe_b, we_b, busy_b;
    logic [7:0] wid_b, wval_b, rid_b, rval_b;
    logic [3:0] st_b;

    always #5 clk = ~clk;

    assign sda_bus = sda_drv & ~oe_a & ~oe_b;
    assign rval_a  = {rid_a[3:0], ~rid_a[3:0]};
    assign rval_b  = {rid_b[3:0], ~rid_b[3:0]};

    i2c_reg_target #(.REG_COUNT(256), .SYNC_STAGES(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .assigned_address_i(7'h40), .aux_address_i(aux_addr), .aux_address_en_i(aux_en),
        .auto_inc_i(auto_inc), .scl_i(scl), .sda_i(sda_bus), .sda_oe_o(oe_a),
        .write_register_id_o(wid_a), .write_register_value_o(wval_a), .write_enable_o(we_a),
        .read_register_id_o(rid_a), .read_register_value_i(rval_a),
        .busy_o(busy_a), .dbg_state_o(st_a)
    );

    i2c_reg_target #(.REG_COUNT(16), .SYNC_STAGES(2)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n),
        .assigned_address_i(7'h50), .aux_address_i(7'h00), .aux_address_en_i(1'b0),
        .auto_inc_i(auto_inc), .scl_i(scl), .sda_i(sda_bus), .sda_oe_o(oe_b),
        .write_register_id_o(wid_b), .write_register_value_o(wval_b), .write_enable_o(we_b),
        .read_register_id_o(rid_b), .read_register_value_i(rval_b),
        .busy_o(busy_b), .dbg_state_o(st_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_unexp  = 0;
    int n_strobe_b = 0;
    logic oe_seen_a = 1'b0;
    logic [15:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe scoreboard and SDA-drive monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (we_a) begin
            if (exp_q.size() == 0) n_unexp++;
            else check_eq("strobe", {wid_a, wval_a}, exp_q.pop_front());
        end
        if (we_b) n_strobe_b++;
        if (oe_a) oe_seen_a = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_drv = 1'b0; wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_drv = 1'b1; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = b[i]; wait_clk(Q);
            scl = 1'b1;     wait_clk(2 * Q);
            scl = 1'b0;     wait_clk(Q);
        end
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        @(negedge clk);
        ack = ~sda_bus;
        wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    task automatic recv_byte(input logic ack_it, output logic [7:0] b);
        sda_drv = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q);
            scl = 1'b1; wait_clk(Q);
            @(negedge clk);
            b[i] = sda_bus;
            wait_clk(Q);
            scl = 1'b0;
        end
        wait_clk(Q);
        sda_drv = ~ack_it; wait_clk(Q);
        scl = 1'b1;        wait_clk(2 * Q);
        scl = 1'b0;        wait_clk(Q);
        sda_drv = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d0, d1;
        logic       seen;

        rst_n = 1'b0; scl = 1'b1; sda_drv = 1'b1;
        aux_addr = 7'h41; aux_en = 1'b0; auto_inc = 1'b0;
        wait_clk(4);
        @(negedge clk);
        check_eq("rst_oe", oe_a, 0);
        check_eq("rst_we", we_a, 0);
        check_eq("rst_wid", wid_a, 0);
        check_eq("rst_wval", wval_a, 0);
        check_eq("rst_ptr", rid_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_state", st_a, 0);
        rst_n = 1'b1;
        wait_clk(4);

        // Single write, no auto-increment.
        exp_q.push_back(16'h06A5);
        i2c_start();
        check_eq("t36_busy", busy_a, 1);
        send_byte(8'h80, ack); check_eq("t36_ack_addr", ack, 1);
        send_byte(8'h06, ack); check_eq("t36_ack_reg", ack, 1);
        send_byte(8'hA5, ack); check_eq("t36_ack_data", ack, 1);
        i2c_stop();
        check_eq("t36_busy_after", busy_a, 0);
        check_eq("t36_ptr", rid_a, 8'h06);
        check_eq("t36_pending", 16'(exp_q.size()), 0);

        // Auto-increment wraps 0xFF -> 0x00.
        auto_inc = 1'b1;
        exp_q.push_back(16'hFF11);
        exp_q.push_back(16'h0022);
        i2c_start();
        send_byte(8'h80, ack); check_eq("t37_ack_addr", ack, 1);
        send_byte(8'hFF, ack); check_eq("t37_ack_reg", ack, 1);
        send_byte(8'h11, ack); check_eq("t37_ack_d0", ack, 1);
        send_byte(8'h22, ack); check_eq("t37_ack_d1", ack, 1);
        i2c_stop();
        check_eq("t37_pending", 16'(exp_q.size()), 0);
        check_eq("t37_ptr", rid_a, 8'h01);

        // Set pointer, repeated START, read two bytes.
        i2c_start();
        send_byte(8'h80, ack); check_eq("t38_ack_addr_w", ack, 1);
        send_byte(8'h10, ack); check_eq("t38_ack_reg", ack, 1);
        i2c_start();
        send_byte(8'h81, ack); check_eq("t38_ack_addr_r", ack, 1);
        recv_byte(1'b1, d0);   check_eq("t38_byte0", d0, 8'h0F);
        recv_byte(1'b0, d1);   check_eq("t38_byte1", d1, 8'h1E);
        wait_clk(Q);
        check_eq("t38_state_nack", st_a, 4'd9);
        check_eq("t38_busy_mid", busy_a, 1);
        i2c_stop();
        check_eq("t38_ptr", rid_a, 8'h12);
        check_eq("t38_busy_after", busy_a, 0);

        // Address 0x41: ignored without aux, accepted with aux.
        oe_seen_a = 1'b0;
        i2c_start();
        send_byte(8'h82, ack); check_eq("t39_nack_addr", ack, 0);
        send_byte(8'h03, ack); check_eq("t39_nack_follow", ack, 0);
        i2c_stop();
        check_eq("t39_oe_never", oe_seen_a, 0);
        check_eq("t39_unexp", 16'(n_unexp), 0);
        aux_en = 1'b1;
        exp_q.push_back(16'h0377);
        i2c_start();
        send_byte(8'h82, ack); check_eq("t39_aux_ack", ack, 1);
        send_byte(8'h03, ack); check_eq("t39_aux_reg", ack, 1);
        send_byte(8'h77, ack); check_eq("t39_aux_data", ack, 1);
        i2c_stop();
        aux_en = 1'b0;
        check_eq("t39_pending", 16'(exp_q.size()), 0);
        check_eq("t39_ptr", rid_a, 8'h04);

        // Read with retained pointer (no register id byte).
        i2c_start();
        send_byte(8'h81, ack); check_eq("t30_ack", ack, 1);
        recv_byte(1'b0, d0);   check_eq("t30_byte", d0, 8'h4B);
        i2c_stop();
        check_eq("t30_ptr", rid_a, 8'h05);

        // REG_COUNT=16 target: out-of-range id is NACKed, pointer kept.
        i2c_start();
        send_byte(8'hA0, ack); check_eq("t40_ack_addr", ack, 1);
        send_byte(8'h05, ack); check_eq("t40_ack_reg_ok", ack, 1);
        i2c_stop();
        check_eq("t40_ptr_set", rid_b, 8'h05);
        i2c_start();
        send_byte(8'hA0, ack); check_eq("t40_ack_addr2", ack, 1);
        send_byte(8'h20, ack); check_eq("t40_nack_reg", ack, 0);
        check_eq("t40_state", st_b, 4'd9);
        send_byte(8'h99, ack); check_eq("t40_nack_data", ack, 0);
        i2c_stop();
        check_eq("t40_ptr_kept", rid_b, 8'h05);
        check_eq("t40_no_strobe", 16'(n_strobe_b), 0);

        // Reset while driving a read data bit (pointer 0x05 -> 0x5A, MSB 0).
        i2c_start();
        send_byte(8'h81, ack); check_eq("t41_ack", ack, 1);
        seen = 1'b0;
        for (int i = 0; i < 4 * Q && !seen; i++) begin
            @(negedge clk);
            seen = oe_a;
        end
        check_eq("t41_oe_before", seen, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t41_oe_reset", oe_a, 0);
        check_eq("t41_state_reset", st_a, 0);
        check_eq("t41_busy_reset", busy_a, 0);
        check_eq("t41_ptr_reset", rid_a, 0);
        wait_clk(3);
        rst_n = 1'b1;
        scl = 1'b1;
        wait_clk(Q);
        exp_q.push_back(16'h083C);
        i2c_start();
        send_byte(8'h80, ack); check_eq("t41_post_addr", ack, 1);
        send_byte(8'h08, ack); check_eq("t41_post_reg", ack, 1);
        send_byte(8'h3C, ack); check_eq("t41_post_data", ack, 1);
        i2c_stop();
        check_eq("t41_pending", 16'(exp_q.size()), 0);
        check_eq("t41_ptr", rid_a, 8'h09);
        check_eq("final_unexp", 16'(n_unexp), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
